// File: rtl/cp0_fwd_pipe.sv
// CP0 write-forwarding pipeline: tracks in-flight CP0 writes across DEPTH stages,
// merges pending masked writes over the architectural value, and exposes retiring writes.
module cp0_fwd_pipe #(
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NRD     = 1,
    localparam int CNT_W  = $clog2(ISSUE_W*DEPTH+1)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [ISSUE_W-1:0]        in_valid,
    input  logic [ISSUE_W*ADDR_W-1:0] in_wa,
    input  logic [ISSUE_W*DATA_W-1:0] in_data,
    input  logic [ISSUE_W*DATA_W-1:0] in_mask,
    input  logic [NRD*ADDR_W-1:0]     rd_addr,
    input  logic [NRD*DATA_W-1:0]     rd_base,
    output logic [NRD*DATA_W-1:0]     rd_data,
    output logic [NRD-1:0]            rd_hit,
    output logic [ISSUE_W-1:0]        ret_valid,
    output logic [ISSUE_W*ADDR_W-1:0] ret_wa,
    output logic [ISSUE_W*DATA_W-1:0] ret_data,
    output logic [ISSUE_W*DATA_W-1:0] ret_mask,
    output logic [CNT_W-1:0]          pend_cnt
);

    // Stage 0 is the youngest; stage DEPTH-1 is the retire stage.
    logic [DEPTH-1:0][ISSUE_W-1:0]             v_q;
    logic [DEPTH-1:0][ISSUE_W-1:0][ADDR_W-1:0] wa_q;
    logic [DEPTH-1:0][ISSUE_W-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0][ISSUE_W-1:0][DATA_W-1:0] mask_q;

    logic             advance;
    logic [CNT_W-1:0] pend_nxt;

    function automatic logic [DATA_W-1:0] merge_bits(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] data,
        input logic [DATA_W-1:0] mask
    );
        return (base & ~mask) | (data & mask);
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [ISSUE_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            n = n + CNT_W'(v[l]);
        end
        return n;
    endfunction

    assign advance = !stall && !flush;

    // Entries still present after the next advance: new lanes plus all but the retire stage.
    always_comb begin
        pend_nxt = popcnt(in_valid);
        for (int s = 0; s < DEPTH-1; s++) begin
            pend_nxt = pend_nxt + popcnt(v_q[s]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q      <= '0;
            pend_cnt <= '0;
        end else if (flush) begin
            v_q      <= '0;
            pend_cnt <= '0;
        end else if (!stall) begin
            for (int s = DEPTH-1; s > 0; s--) begin
                v_q[s] <= v_q[s-1];
            end
            v_q[0]   <= in_valid;
            pend_cnt <= pend_nxt;
        end
    end

    // Payload carries no reset; it is only meaningful where v_q is set.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int s = DEPTH-1; s > 0; s--) begin
                wa_q[s]   <= wa_q[s-1];
                data_q[s] <= data_q[s-1];
                mask_q[s] <= mask_q[s-1];
            end
            wa_q[0]   <= in_wa;
            data_q[0] <= in_data;
            mask_q[0] <= in_mask;
        end
    end

    assign ret_valid = v_q[DEPTH-1] & {ISSUE_W{~stall}};
    assign ret_wa    = wa_q[DEPTH-1];
    assign ret_data  = data_q[DEPTH-1];
    assign ret_mask  = mask_q[DEPTH-1];

    // Oldest-to-youngest walk so later (younger) writes override earlier bits.
    always_comb begin
        logic [DATA_W-1:0] val;
        logic              hit;
        rd_data = '0;
        rd_hit  = '0;
        for (int p = 0; p < NRD; p++) begin
            val = rd_base[p*DATA_W +: DATA_W];
            hit = 1'b0;
            for (int s = DEPTH-1; s >= 0; s--) begin
                for (int l = 0; l < ISSUE_W; l++) begin
                    if (v_q[s][l] && (wa_q[s][l] == rd_addr[p*ADDR_W +: ADDR_W])) begin
                        val = merge_bits(val, data_q[s][l], mask_q[s][l]);
                        hit = 1'b1;
                    end
                end
            end
            rd_data[p*DATA_W +: DATA_W] = val;
            rd_hit[p]                   = hit;
        end
    end

endmodule

// File: tb/tb_cp0_fwd_pipe.sv
// Directed bench for cp0_fwd_pipe: expectations queued as stimulus is applied,
// then popped and compared against the DUT outputs.
module tb_cp0_fwd_pipe;
    localparam int ISSUE_W = 2;
    localparam int DEPTH   = 3;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int NRD     = 1;
    localparam int CNT_W   = $clog2(ISSUE_W*DEPTH+1);

    localparam int S_RD   = 0;
    localparam int S_HIT  = 1;
    localparam int S_RETV = 2;
    localparam int S_PEND = 3;
    localparam int S_RETD = 4;
    localparam int S_RETA = 5;
    localparam int S_RETM = 6;

    logic                      clk;
    logic                      resetn;
    logic                      stall;
    logic                      flush;
    logic [ISSUE_W-1:0]        in_valid;
    logic [ISSUE_W*ADDR_W-1:0] in_wa;
    logic [ISSUE_W*DATA_W-1:0] in_data;
    logic [ISSUE_W*DATA_W-1:0] in_mask;
    logic [NRD*ADDR_W-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0]     rd_base;
    logic [NRD*DATA_W-1:0]     rd_data;
    logic [NRD-1:0]            rd_hit;
    logic [ISSUE_W-1:0]        ret_valid;
    logic [ISSUE_W*ADDR_W-1:0] ret_wa;
    logic [ISSUE_W*DATA_W-1:0] ret_data;
    logic [ISSUE_W*DATA_W-1:0] ret_mask;
    logic [CNT_W-1:0]          pend_cnt;

    cp0_fwd_pipe #(
        .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NRD(NRD)
    ) dut (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_wa(in_wa), .in_data(in_data), .in_mask(in_mask),
        .rd_addr(rd_addr), .rd_base(rd_base), .rd_data(rd_data), .rd_hit(rd_hit),
        .ret_valid(ret_valid), .ret_wa(ret_wa), .ret_data(ret_data), .ret_mask(ret_mask),
        .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] obs(input int sig);
        case (sig)
            S_RD:    return 64'(rd_data);
            S_HIT:   return 64'(rd_hit);
            S_RETV:  return 64'(ret_valid);
            S_PEND:  return 64'(pend_cnt);
            S_RETD:  return 64'(ret_data);
            S_RETA:  return 64'(ret_wa);
            S_RETM:  return 64'(ret_mask);
            default: return 64'hx;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sig, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [63:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] v,
                       input logic [7:0] wa0, input logic [31:0] d0, input logic [31:0] m0,
                       input logic [7:0] wa1, input logic [31:0] d1, input logic [31:0] m1);
        in_valid = v;
        in_wa    = {wa1, wa0};
        in_data  = {d1, d0};
        in_mask  = {m1, m0};
    endtask

    task automatic drv_idle();
        drv(2'b00, 8'h0, 32'h0, 32'h0, 8'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn  = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        drv_idle();
        rd_addr = 8'h60;
        rd_base = 32'h0040FF01;
        tick();
        tick();
        expect_v("rst_pend", S_PEND, 64'd0);
        expect_v("rst_retv", S_RETV, 64'd0);
        expect_v("rst_hit",  S_HIT,  64'd0);
        expect_v("rst_rd",   S_RD,   64'h0040FF01);
        check_sb();
        resetn = 1'b1;
        tick();
        expect_v("post_rst_rd", S_RD, 64'h0040FF01);
        check_sb();

        // single full-mask write on lane 0
        drv(2'b01, 8'h60, 32'h12345678, 32'hFFFFFFFF, 8'h0, 32'h0, 32'h0);
        expect_v("sw_same_cycle_hit", S_HIT, 64'd0);
        expect_v("sw_same_cycle_rd",  S_RD,  64'h0040FF01);
        check_sb();
        tick();
        drv_idle();
        for (int c = 1; c <= 3; c++) begin
            expect_v("sw_hit",  S_HIT,  64'd1);
            expect_v("sw_rd",   S_RD,   64'h12345678);
            expect_v("sw_pend", S_PEND, 64'd1);
            expect_v("sw_retv", S_RETV, (c == 3) ? 64'd1 : 64'd0);
            if (c == 3) begin
                expect_v("sw_ret_data", S_RETD, {32'h0, 32'h12345678});
                expect_v("sw_ret_wa",   S_RETA, 64'h0060);
                expect_v("sw_ret_mask", S_RETM, {32'h0, 32'hFFFFFFFF});
            end
            check_sb();
            tick();
        end
        expect_v("sw_drain_pend", S_PEND, 64'd0);
        expect_v("sw_drain_hit",  S_HIT,  64'd0);
        expect_v("sw_drain_retv", S_RETV, 64'd0);
        expect_v("sw_drain_rd",   S_RD,   64'h0040FF01);
        check_sb();

        // masked merge: older low byte, younger second byte
        rd_base = 32'hFFFF0000;
        drv(2'b01, 8'h60, 32'h000000AA, 32'h000000FF, 8'h0, 32'h0, 32'h0);
        tick();
        drv(2'b01, 8'h60, 32'h00001100, 32'h0000FF00, 8'h0, 32'h0, 32'h0);
        expect_v("mm_old_only", S_RD, 64'hFFFF00AA);
        check_sb();
        tick();
        drv_idle();
        expect_v("mm_rd",   S_RD,   64'hFFFF11AA);
        expect_v("mm_hit",  S_HIT,  64'd1);
        expect_v("mm_pend", S_PEND, 64'd2);
        check_sb();
        tick(); tick(); tick();
        expect_v("mm_drain_pend", S_PEND, 64'd0);
        check_sb();

        // same stage, same address: higher lane wins
        drv(2'b11, 8'h60, 32'h1, 32'hFFFFFFFF, 8'h60, 32'h2, 32'hFFFFFFFF);
        tick();
        drv_idle();
        expect_v("ss_rd",   S_RD,   64'h2);
        expect_v("ss_hit",  S_HIT,  64'd1);
        expect_v("ss_pend", S_PEND, 64'd2);
        check_sb();
        tick(); tick();
        expect_v("ss_retv", S_RETV, 64'd3);
        expect_v("ss_retd", S_RETD, {32'h2, 32'h1});
        check_sb();
        tick();
        expect_v("ss_drain_pend", S_PEND, 64'd0);
        check_sb();
        drv(2'b11, 8'h60, 32'h1, 32'hFFFFFFFF, 8'h60, 32'h2, 32'h0);
        tick();
        drv_idle();
        expect_v("ss_m0_rd",  S_RD,  64'h1);
        expect_v("ss_m0_hit", S_HIT, 64'd1);
        check_sb();
        tick(); tick(); tick();

        // stall with an entry in the retire stage
        rd_base = 32'h0;
        drv(2'b01, 8'h60, 32'hCAFEBABE, 32'hFFFFFFFF, 8'h0, 32'h0, 32'h0);
        tick();
        drv_idle();
        tick(); tick();
        expect_v("st_pre_retv", S_RETV, 64'd1);
        expect_v("st_pre_pend", S_PEND, 64'd1);
        check_sb();
        stall = 1'b1;
        drv(2'b11, 8'h60, 32'hDEADBEEF, 32'hFFFFFFFF, 8'h60, 32'hDEADBEEF, 32'hFFFFFFFF);
        for (int c = 0; c < 4; c++) begin
            expect_v("st_retv", S_RETV, 64'd0);
            expect_v("st_rd",   S_RD,   64'hCAFEBABE);
            expect_v("st_hit",  S_HIT,  64'd1);
            expect_v("st_pend", S_PEND, 64'd1);
            check_sb();
            tick();
        end
        stall = 1'b0;
        drv_idle();
        expect_v("st_rel_retv", S_RETV, 64'd1);
        expect_v("st_rel_retd", S_RETD, {32'h0, 32'hCAFEBABE});
        check_sb();
        tick();
        expect_v("st_out_pend", S_PEND, 64'd0);
        expect_v("st_out_hit",  S_HIT,  64'd0);
        expect_v("st_out_retv", S_RETV, 64'd0);
        check_sb();

        // flush while stalled
        drv(2'b01, 8'h60, 32'h11111111, 32'hFFFFFFFF, 8'h0, 32'h0, 32'h0);
        tick();
        drv_idle();
        tick(); tick();
        stall = 1'b1;
        flush = 1'b1;
        expect_v("fs_retv", S_RETV, 64'd0);
        check_sb();
        tick();
        stall = 1'b0;
        flush = 1'b0;
        expect_v("fs_pend", S_PEND, 64'd0);
        expect_v("fs_hit",  S_HIT,  64'd0);
        expect_v("fs_retv_after", S_RETV, 64'd0);
        check_sb();

        // flush without stall: the retire stage still retires
        drv(2'b01, 8'h60, 32'h22222222, 32'hFFFFFFFF, 8'h0, 32'h0, 32'h0);
        tick();
        drv(2'b01, 8'h60, 32'h33333333, 32'hFFFFFFFF, 8'h0, 32'h0, 32'h0);
        tick();
        drv_idle();
        tick();
        flush = 1'b1;
        drv(2'b01, 8'h60, 32'h44444444, 32'hFFFFFFFF, 8'h0, 32'h0, 32'h0);
        expect_v("fn_retv", S_RETV, 64'd1);
        expect_v("fn_retd", S_RETD, {32'h0, 32'h22222222});
        expect_v("fn_rd",   S_RD,   64'h33333333);
        expect_v("fn_pend", S_PEND, 64'd2);
        check_sb();
        tick();
        flush = 1'b0;
        drv_idle();
        expect_v("fn_after_pend", S_PEND, 64'd0);
        expect_v("fn_after_hit",  S_HIT,  64'd0);
        expect_v("fn_after_retv", S_RETV, 64'd0);
        expect_v("fn_after_rd",   S_RD,   64'h0);
        check_sb();
        tick();
        expect_v("fn_discard_pend", S_PEND, 64'd0);
        expect_v("fn_discard_hit",  S_HIT,  64'd0);
        check_sb();

        // asynchronous reset mid-stream
        rd_base = 32'h0040FF01;
        drv(2'b11, 8'h60, 32'h55, 32'hFFFFFFFF, 8'h61, 32'h66, 32'hFFFFFFFF);
        tick();
        drv_idle();
        tick(); tick();
        expect_v("ar_pre_retv", S_RETV, 64'd3);
        expect_v("ar_pre_hit",  S_HIT,  64'd1);
        check_sb();
        resetn = 1'b0;
        expect_v("ar_retv", S_RETV, 64'd0);
        expect_v("ar_pend", S_PEND, 64'd0);
        expect_v("ar_hit",  S_HIT,  64'd0);
        expect_v("ar_rd",   S_RD,   64'h0040FF01);
        check_sb();
        tick();
        resetn = 1'b1;
        tick();
        expect_v("ar_post_rd",  S_RD,  64'h0040FF01);
        expect_v("ar_post_hit", S_HIT, 64'd0);
        check_sb();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
